// File: rtl/mux3_bus_arbiter_if.sv
// Bus bundle shared by the three requesters and the round-robin arbiter.
// The arbiter connects through the slave modport; the requester side uses master.
interface mux3_bus_arbiter_if #(
  parameter int width = 32
);
  logic [2:0]       req;
  logic [2:0]       last;
  logic [width-1:0] dina;
  logic [width-1:0] dinb;
  logic [width-1:0] dinc;
  logic [width-1:0] dout;
  logic [2:0]       gnt;
  logic [1:0]       s;
  logic             busy;
  logic             preempt;

  modport master (
    output req, last, dina, dinb, dinc,
    input  dout, gnt, s, busy, preempt
  );

  modport slave (
    input  req, last, dina, dinb, dinc,
    output dout, gnt, s, busy, preempt
  );
endinterface

// File: rtl/mux3_bus_arbiter.sv
// Round-robin arbiter that shares one 3:1 data mux between three requesters.
// Ownership is held for a burst of at most MAXBURST cycles; gnt/s/busy/preempt
// are registered, dout is the combinational mux output gated by busy.
// Optional per-requester grant counters: define MUX3_ARB_STATS_EN.
module mux3_bus_arbiter #(
  parameter int width    = 32,
  parameter int MAXBURST = 8,
  parameter int CNTW     = 16
) (
  input  logic            clk,
  input  logic            rst,
`ifdef MUX3_ARB_STATS_EN
  input  logic            stat_clr,
  output logic [CNTW-1:0] gcnt0,
  output logic [CNTW-1:0] gcnt1,
  output logic [CNTW-1:0] gcnt2,
`endif
  mux3_bus_arbiter_if.slave bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [7:0] BLAST = 8'(MAXBURST - 1);

  state_t     state, nstate;
  logic [1:0] owner, nowner;
  logic [1:0] ptr, nptr;
  logic [7:0] bcnt, nbcnt;
  logic       start;
  logic       cut;
  logic [2:0] others;
  logic [2:0] elig;
  logic [2:0] ngnt;
  logic [1:0] ns;
  logic       nbusy;
  logic       npreempt;

  // (x + 1) mod 3 for a requester index
  function automatic logic [1:0] nxt3(input logic [1:0] x);
    case (x)
      2'd0:    nxt3 = 2'd1;
      2'd1:    nxt3 = 2'd2;
      default: nxt3 = 2'd0;
    endcase
  endfunction

  // Requester index to one-hot grant vector
  function automatic logic [2:0] dec(input logic [1:0] x);
    case (x)
      2'd0:    dec = 3'b001;
      2'd1:    dec = 3'b010;
      2'd2:    dec = 3'b100;
      default: dec = 3'b000;
    endcase
  endfunction

  // First set request searching p, p+1, p+2 (mod 3); caller guarantees r != 0
  function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] p);
    logic [1:0] a, b, c;
    a = p;
    b = nxt3(p);
    c = nxt3(b);
    if (r[a]) begin
      pick = a;
    end else if (r[b]) begin
      pick = b;
    end else begin
      pick = c;
    end
  endfunction

  // State, arbitration bookkeeping and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= 2'd0;
      ptr         <= 2'd0;
      bcnt        <= 8'd0;
      bus.gnt     <= 3'b000;
      bus.s       <= 2'b00;
      bus.busy    <= 1'b0;
      bus.preempt <= 1'b0;
    end else begin
      state       <= nstate;
      owner       <= nowner;
      ptr         <= nptr;
      bcnt        <= nbcnt;
      bus.gnt     <= ngnt;
      bus.s       <= ns;
      bus.busy    <= nbusy;
      bus.preempt <= npreempt;
    end
  end

  // Next state: grant from IDLE, or release/re-arbitrate at the end of a burst
  always_comb begin
    nstate = state;
    nowner = owner;
    nptr   = ptr;
    nbcnt  = bcnt;
    start  = 1'b0;
    cut    = 1'b0;
    others = 3'b000;
    elig   = 3'b000;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          nstate = GRANT;
          nowner = pick(bus.req, ptr);
          nbcnt  = 8'd0;
          start  = 1'b1;
        end else begin
          nstate = IDLE;
        end
      end
      GRANT: begin
        if (bus.last[owner] || !bus.req[owner] || (bcnt == BLAST)) begin
          // Burst limit alone (owner neither finished nor withdrew) is a preemption
          cut    = (bcnt == BLAST) && !bus.last[owner] && bus.req[owner];
          nptr   = nxt3(owner);
          // The outgoing owner only competes when nobody else is asking
          others = bus.req & ~dec(owner);
          elig   = (|others) ? others : bus.req;
          nbcnt  = 8'd0;
          if (|elig) begin
            nstate = GRANT;
            nowner = pick(elig, nxt3(owner));
            start  = 1'b1;
          end else begin
            nstate = IDLE;
          end
        end else begin
          nbcnt = bcnt + 8'd1;
        end
      end
      default: begin
        nstate = IDLE;
      end
    endcase
  end

  // Output decode of the next state, registered above
  always_comb begin
    nbusy    = (nstate == GRANT);
    npreempt = cut;
    if (nstate == GRANT) begin
      ngnt = dec(nowner);
      ns   = nowner;
    end else begin
      ngnt = 3'b000;
      ns   = 2'b00;
    end
  end

  // Shared bus mux; zero when idle or on the unused select code
  always_comb begin
    if (bus.busy) begin
      case (bus.s)
        2'b00:   bus.dout = bus.dina;
        2'b01:   bus.dout = bus.dinb;
        2'b10:   bus.dout = bus.dinc;
        default: bus.dout = {width{1'b0}};
      endcase
    end else begin
      bus.dout = {width{1'b0}};
    end
  end

`ifdef MUX3_ARB_STATS_EN
  localparam logic [CNTW-1:0] CMAX = {CNTW{1'b1}};

  // Saturating ownership-start counters; clear wins over increment
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      gcnt0 <= {CNTW{1'b0}};
      gcnt1 <= {CNTW{1'b0}};
      gcnt2 <= {CNTW{1'b0}};
    end else if (start) begin
      case (nowner)
        2'd0:    if (gcnt0 != CMAX) gcnt0 <= gcnt0 + {{(CNTW-1){1'b0}}, 1'b1};
        2'd1:    if (gcnt1 != CMAX) gcnt1 <= gcnt1 + {{(CNTW-1){1'b0}}, 1'b1};
        2'd2:    if (gcnt2 != CMAX) gcnt2 <= gcnt2 + {{(CNTW-1){1'b0}}, 1'b1};
        default: gcnt0 <= gcnt0;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_mux3_bus_arbiter.sv
// Directed self-checking bench for mux3_bus_arbiter (MAXBURST = 8).
// Covers the counter outputs as well when MUX3_ARB_STATS_EN is defined.
module tb_mux3_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef MUX3_ARB_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] gcnt0, gcnt1, gcnt2;
`endif

  mux3_bus_arbiter_if #(.width(32)) bus ();

  mux3_bus_arbiter #(.width(32), .MAXBURST(8), .CNTW(16)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef MUX3_ARB_STATS_EN
    .stat_clr (stat_clr),
    .gcnt0    (gcnt0),
    .gcnt1    (gcnt1),
    .gcnt2    (gcnt2),
`endif
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = 3'b000;
    bus.last = 3'b000;
    tick();
    rst = 1'b0;
  endtask

  logic [2:0] seq_gnt [4];

  initial begin
    bus.req  = 3'b000;
    bus.last = 3'b000;
    bus.dina = 32'hAAAA0000;
    bus.dinb = 32'hBBBB1111;
    bus.dinc = 32'hCCCC2222;
    seq_gnt[0] = 3'b001;
    seq_gnt[1] = 3'b010;
    seq_gnt[2] = 3'b100;
    seq_gnt[3] = 3'b001;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_s", 32'(bus.s), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_pre", 32'(bus.preempt), 32'h0);
    chk("rst_dout", bus.dout, 32'h0);

    // Single requester, final beat on the 3rd granted cycle
    bus.req = 3'b001;
    chk("t1_latency", 32'(bus.gnt), 32'h0);
    tick();
    chk("t1_gnt", 32'(bus.gnt), 32'h1);
    chk("t1_s", 32'(bus.s), 32'h0);
    chk("t1_dout1", bus.dout, 32'hAAAA0000);
    tick();
    chk("t1_dout2", bus.dout, 32'hAAAA0000);
    tick();
    chk("t1_dout3", bus.dout, 32'hAAAA0000);
    bus.req  = 3'b000;
    bus.last = 3'b001;
    tick();
    bus.last = 3'b000;
    chk("t1_rel_gnt", 32'(bus.gnt), 32'h0);
    chk("t1_rel_busy", 32'(bus.busy), 32'h0);
    chk("t1_rel_dout", bus.dout, 32'h0);

    // All three requesting: rotation limited by MAXBURST
    do_reset();
    bus.req = 3'b111;
    tick();
    for (int k = 0; k < 32; k++) begin
      chk($sformatf("t2_gnt_%0d", k), 32'(bus.gnt), 32'(seq_gnt[k / 8]));
      chk($sformatf("t2_pre_%0d", k), 32'(bus.preempt), ((k % 8 == 0) && (k > 0)) ? 32'h1 : 32'h0);
      chk($sformatf("t2_busy_%0d", k), 32'(bus.busy), 32'h1);
      if (k == 31) bus.req = 3'b000;
      tick();
    end
    chk("t2_end_gnt", 32'(bus.gnt), 32'h0);
    chk("t2_end_pre", 32'(bus.preempt), 32'h0);

    // Early last by requester 0 hands off to 1, then pointer favours 2
    do_reset();
    bus.req = 3'b011;
    tick();
    chk("t3_gnt_a", 32'(bus.gnt), 32'h1);
    tick();
    chk("t3_gnt_b", 32'(bus.gnt), 32'h1);
    bus.last = 3'b001;
    tick();
    bus.last = 3'b000;
    chk("t3_handoff", 32'(bus.gnt), 32'h2);
    chk("t3_s", 32'(bus.s), 32'h1);
    chk("t3_dout", bus.dout, 32'hBBBB1111);
    chk("t3_pre", 32'(bus.preempt), 32'h0);
    bus.req  = 3'b111;
    bus.last = 3'b010;
    tick();
    bus.last = 3'b000;
    chk("t3_ptr_gnt", 32'(bus.gnt), 32'h4);
    chk("t3_ptr_s", 32'(bus.s), 32'h2);
    chk("t3_ptr_dout", bus.dout, 32'hCCCC2222);

    // Sole requester re-granted after each final beat, no idle gap
    do_reset();
    bus.req = 3'b100;
    tick();
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("t4_gnt_%0d", k), 32'(bus.gnt), 32'h4);
      chk($sformatf("t4_busy_%0d", k), 32'(bus.busy), 32'h1);
      chk($sformatf("t4_pre_%0d", k), 32'(bus.preempt), 32'h0);
      bus.last = (k % 2 == 0) ? 3'b100 : 3'b000;
      tick();
    end
    bus.last = 3'b000;

    // Reset on the 4th cycle of a burst
    do_reset();
    bus.req = 3'b010;
    tick();
    tick();
    tick();
    tick();
    chk("t5_c4_gnt", 32'(bus.gnt), 32'h2);
    rst = 1'b1;
    tick();
    chk("t5_gnt", 32'(bus.gnt), 32'h0);
    chk("t5_s", 32'(bus.s), 32'h0);
    chk("t5_busy", 32'(bus.busy), 32'h0);
    chk("t5_pre", 32'(bus.preempt), 32'h0);
    rst = 1'b0;
    tick();
    chk("t5_regrant", 32'(bus.gnt), 32'h2);
    chk("t5_regrant_busy", 32'(bus.busy), 32'h1);

`ifdef MUX3_ARB_STATS_EN
    // Three ownership starts for requester 1, one for requester 2
    do_reset();
    bus.req  = 3'b010;
    bus.last = 3'b010;
    tick();
    tick();
    tick();
    bus.req  = 3'b100;
    bus.last = 3'b000;
    tick();
    chk("st_gnt2", 32'(bus.gnt), 32'h4);
    bus.req = 3'b000;
    tick();
    chk("st_gcnt0", 32'(gcnt0), 32'd0);
    chk("st_gcnt1", 32'(gcnt1), 32'd3);
    chk("st_gcnt2", 32'(gcnt2), 32'd1);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("st_clr0", 32'(gcnt0), 32'd0);
    chk("st_clr1", 32'(gcnt1), 32'd0);
    chk("st_clr2", 32'(gcnt2), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux3_bus_arbiter.md
Name: mux3_bus_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one 3-to-1 datapath multiplexer between three requesters.
- Requester 0 drives dina, requester 1 drives dinb, requester 2 drives dinc.
- The block grants ownership, holds it for a burst, and drives the 2-bit mux select from registered state.
- Sits in front of a shared 32-bit bus, e.g. a shared write-back or memory port in the processor.

Parameters:
- width, 32, data width of dina/dinb/dinc/dout
- MAXBURST, 8, maximum consecutive granted cycles per ownership (valid range 2..255)
- CNTW, 16, width of per-requester grant counters (optional feature only)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous active-high reset
- req  input  3  request per requester, bit i = requester i
- last  input  3  bit i: requester i's final beat this cycle
- dina  input  width  data from requester 0
- dinb  input  width  data from requester 1
- dinc  input  width  data from requester 2
- dout  output  width  shared bus data
- gnt  output  3  one-hot grant, registered
- s  output  2  mux select, registered: 00=dina, 01=dinb, 10=dinc
- busy  output  1  high while any grant is active
- preempt  output  1  one-cycle pulse when a grant is cut by MAXBURST

Behaviour:
- Reset (rst high at a clk edge):
  - State IDLE; gnt=000, s=00, busy=0, preempt=0.
  - Round-robin pointer ptr=0 (requester 0 highest priority); burst counter bcnt=0.
- dout is combinational: the selected input when busy=1, else all zeros.
  - s=11 is never produced; if forced, dout=0.
- States:
  - IDLE: if req!=0, choose the first requester with req set, searching ptr, ptr+1, ptr+2 (mod 3). Go to GRANT; gnt/s/busy are valid the next cycle (1-cycle grant latency).
  - GRANT: owner o holds gnt[o]=1; bcnt increments every cycle, starting at 0 on the first granted cycle.
- Release condition, evaluated each GRANT cycle:
  - (a) last[o]=1, or
  - (b) req[o]=0, or
  - (c) bcnt==MAXBURST-1.
  - Under (c) with neither (a) nor (b), preempt=1 on the following cycle.
  - A beat with last[o]=1 is still transferred; ownership ends after that edge.
- On release:
  - ptr <= (o+1) mod 3.
  - Re-arbitrate at the same edge among req (excluding bit o if any other bit is set) using the new ptr. This gives back-to-back handoff with no idle cycle.
  - If no eligible request remains, go to IDLE.
- Owner re-grant: o is re-granted immediately only when it is the sole requester, which starts a new burst with bcnt=0.
- last bits of non-owners are ignored.
- req changes of non-owners during GRANT do not disturb the current owner.
- Simultaneous rst and req: reset wins.
- Reset mid-burst: grant drops the next cycle; no preempt pulse.
- gnt is always one-hot or zero; s always matches gnt (gnt=001→00, 010→01, 100→10, 000→00).

Optional Feature:
- Macro: MUX3_ARB_STATS_EN
- With the macro defined:
  - Adds outputs gcnt0, gcnt1, gcnt2 (CNTW bits each) and input stat_clr (1 bit).
  - gcnt[i] increments by 1 on each cycle of a new ownership start for requester i (transition into gnt[i]=1, including an immediate re-grant).
  - Counters saturate at all ones.
  - Cleared by rst or stat_clr; stat_clr has priority over an increment in the same cycle.
- Without the macro: these ports and counters do not exist; arbitration behaviour is identical.

Test Plan:
- Reset then req=001, last pulsed on the 3rd granted cycle, dina=32'hAAAA0000 → gnt=001 and s=00 one cycle after req; dout=AAAA0000 for 3 cycles; then gnt=000, busy=0, dout=0.
- req=111 held, last=000, MAXBURST=8 → grants rotate 0→1→2→0, each exactly 8 cycles; preempt pulses once per handoff; no idle cycle between owners.
- req=011 with requester 0 asserting last on its 2nd beat → gnt goes 001 for 2 cycles, then 010 on the very next cycle; ptr then favours requester 2.
- req=100 only, last[2] every 2nd cycle → gnt stays 100 continuously with re-grants; busy never drops; preempt stays 0.
- rst asserted on the 4th cycle of a burst with req=010 → next cycle gnt=000, s=00, busy=0, preempt=0; after rst drops with req=010, the grant returns after one cycle.
- With MUX3_ARB_STATS_EN: three grants to requester 1 and one to requester 2 → gcnt1=3, gcnt2=1, gcnt0=0; stat_clr for 1 cycle → all counters 0.
